// File: rtl/multi_link_supervisor.sv
// Supervises n_ch decoded command links and forwards the selected link's speed/dir.
// Build option: define OBSTACLE_STOP_EN to force stop_speed_cmd while any obstacle sensor is high.
module multi_link_supervisor #(
  parameter int n_ch           = 2,
  parameter int cmd_l          = 4,
  parameter int def_speed_cmd  = 5,
  parameter int def_dir_cmd    = 8,
  parameter int stop_speed_cmd = 0,
  parameter int max_err_rate   = 5,
  parameter int link_timeout   = 2_000_000,
  parameter int acq_frames     = 3,
  localparam int ch_w = (n_ch > 1) ? $clog2(n_ch) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [n_ch-1:0]       ch_avl,
  input  logic [n_ch*cmd_l-1:0] ch_speed,
  input  logic [n_ch*cmd_l-1:0] ch_dir,
  input  logic [n_ch*4-1:0]     ch_err,
  input  logic                  f1,
  input  logic                  f2,
  input  logic                  b1,
  input  logic                  b2,
  output logic [cmd_l-1:0]      speed_cmd_o,
  output logic [cmd_l-1:0]      dir_cmd_o,
  output logic                  cmd_vld,
  output logic [ch_w-1:0]       active_ch,
  output logic [n_ch-1:0]       link_ok,
  output logic [1:0]            state_o,
  output logic [7:0]            failover_cnt
);
  // cmd_vld is a one-cycle valid pulse with no ready: the consumer must take
  // speed_cmd_o/dir_cmd_o in the cycle cmd_vld is high; they hold afterwards.
  localparam int age_w = $clog2(link_timeout + 1);
  localparam int acq_w = $clog2(acq_frames + 1);
  localparam logic [age_w-1:0] age_max  = age_w'(link_timeout);
  localparam logic [3:0]       err_max  = 4'(max_err_rate);
  localparam logic [acq_w-1:0] acq_last = acq_w'(acq_frames);

  typedef enum logic [1:0] {SAFE = 2'd0, ACQ = 2'd1, RUN = 2'd2, SWITCH = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [ch_w-1:0]    active_q, active_d;
  logic [acq_w-1:0]   acq_q, acq_d;
  logic [cmd_l-1:0]   speed_q, speed_d, dir_q, dir_d;
  logic               vld_q, vld_d;
  logic [7:0]         fail_q, fail_d;
  logic [age_w-1:0]   age_q [n_ch];
  logic [age_w-1:0]   age_d [n_ch];
  logic [3:0]         err_q [n_ch];
  logic [3:0]         err_d [n_ch];
  logic [n_ch-1:0]    seen_q, seen_d, link_ok_q, health_d;
  logic [n_ch-1:0]    act_mask;
  logic [ch_w:0]      low_any, low_other;
  logic [cmd_l-1:0]   sel_speed, sel_dir;
  logic               frame_ok, obstacle;

`ifdef OBSTACLE_STOP_EN
  assign obstacle = f1 | f2 | b1 | b2;
`else
  logic unused_sensors;
  assign unused_sensors = f1 | f2 | b1 | b2;
  assign obstacle = 1'b0;
`endif

  // Returns {found, index} of the lowest set bit.
  function automatic logic [ch_w:0] lowest(input logic [n_ch-1:0] mask);
    logic [ch_w:0] r;
    r = '0;
    for (int k = n_ch - 1; k >= 0; k--)
      if (mask[k]) r = {1'b1, ch_w'(k)};
    return r;
  endfunction

  // Health is judged on post-update link state so a frame arriving as the age
  // would saturate keeps the link alive.
  always_comb begin
    for (int k = 0; k < n_ch; k++) begin
      seen_d[k] = seen_q[k];
      err_d[k]  = err_q[k];
      age_d[k]  = (age_q[k] == age_max) ? age_q[k] : age_q[k] + 1'b1;
      if (ch_avl[k]) begin
        age_d[k]  = '0;
        seen_d[k] = 1'b1;
        err_d[k]  = ch_err[k*4 +: 4];
      end
      health_d[k] = seen_d[k] && (age_d[k] < age_max) && (err_d[k] <= err_max);
    end
  end

  always_comb begin
    act_mask           = '0;
    act_mask[active_q] = 1'b1;
    low_any   = lowest(health_d);
    low_other = lowest(health_d & ~act_mask);
    sel_speed = ch_speed[active_q*cmd_l +: cmd_l];
    sel_dir   = ch_dir[active_q*cmd_l +: cmd_l];
    frame_ok  = ch_avl[active_q] && (ch_err[active_q*4 +: 4] <= err_max);
    state_d  = state_q;
    active_d = active_q;
    acq_d    = acq_q;
    speed_d  = speed_q;
    dir_d    = dir_q;
    vld_d    = 1'b0;
    fail_d   = fail_q;
    case (state_q)
      SAFE: if (low_any[ch_w]) begin
        state_d  = ACQ;
        active_d = low_any[ch_w-1:0];
        // The frame that makes the candidate healthy is its first acquisition frame.
        acq_d    = ch_avl[low_any[ch_w-1:0]] ? acq_w'(1) : '0;
      end
      ACQ: begin
        if (!health_d[active_q]) state_d = SAFE;
        else if (frame_ok) begin
          if (acq_q + 1'b1 == acq_last) begin
            state_d = RUN;
            speed_d = sel_speed;
            dir_d   = sel_dir;
            vld_d   = 1'b1;
          end else acq_d = acq_q + 1'b1;
        end
      end
      RUN: begin
        if (!health_d[active_q]) begin
          if (low_other[ch_w]) begin
            state_d = SWITCH;
            fail_d  = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
          end else state_d = SAFE;
        end else if (frame_ok) begin
          speed_d = sel_speed;
          dir_d   = sel_dir;
          vld_d   = 1'b1;
        end
      end
      SWITCH: begin
        if (low_other[ch_w]) begin
          state_d  = RUN;
          active_d = low_other[ch_w-1:0];
        end else state_d = SAFE;
      end
      default: state_d = SAFE;
    endcase
    if (state_d == SAFE) begin
      speed_d = cmd_l'(def_speed_cmd);
      dir_d   = cmd_l'(def_dir_cmd);
    end
    if (obstacle) speed_d = cmd_l'(stop_speed_cmd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SAFE;
      active_q  <= '0;
      acq_q     <= '0;
      speed_q   <= cmd_l'(def_speed_cmd);
      dir_q     <= cmd_l'(def_dir_cmd);
      vld_q     <= 1'b0;
      fail_q    <= '0;
      seen_q    <= '0;
      link_ok_q <= '0;
      for (int k = 0; k < n_ch; k++) begin
        age_q[k] <= age_max;
        err_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      acq_q     <= acq_d;
      speed_q   <= speed_d;
      dir_q     <= dir_d;
      vld_q     <= vld_d;
      fail_q    <= fail_d;
      seen_q    <= seen_d;
      link_ok_q <= health_d;
      for (int k = 0; k < n_ch; k++) begin
        age_q[k] <= age_d[k];
        err_q[k] <= err_d[k];
      end
    end
  end

  assign speed_cmd_o  = speed_q;
  assign dir_cmd_o    = dir_q;
  assign cmd_vld      = vld_q;
  assign active_ch    = active_q;
  assign link_ok      = link_ok_q;
  assign state_o      = state_q;
  assign failover_cnt = fail_q;
endmodule
